// File: rtl/dp_mem_responder.sv
// -----------------------------------------------------------------------------
// dp_mem_responder
//
// Memory-side responder for the datapath request interface. Instruction fetches
// and data loads/stores from the datapath are serialized onto one single-port
// RAM with a ready handshake. Data requests win over fetches. Each completed
// access returns a one-cycle hit pulse (ihit / dhit).
//
// Ports:
//   CLK, nRST             clock; synchronous active-low reset
//   halt                  blocks acceptance of new instruction fetches
//   imemREN, imemaddr     fetch request / address
//   ihit, imemload        fetch done pulse / fetched word (held between hits)
//   dmemREN, dmemWEN      data load / store request
//   dmemaddr, dmemstore   data address / store data
//   dhit, dmemload        data done pulse / loaded word (held between hits)
//   ramREN, ramWEN        RAM read / write strobes
//   ramaddr, ramstore     RAM word address (bits [1:0] = 0) / write data
//   ramload, ramready     RAM read data / access complete this cycle
//   mem_err               sticky error flag (RAM timeout or REN+WEN together)
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data word width
//   TIMEOUT  max strobe cycles per access before giving up; 0 = no watchdog
//
// Optional feature (macro DP_MEM_ILAST_BUF_EN):
//   One-entry buffer of the last fetched address/instruction. A fetch that
//   matches a valid entry is answered from the buffer without a RAM access.
// -----------------------------------------------------------------------------
module dp_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Last count value of an access before the watchdog fires; the counter
  // starts at 0 on the first strobe cycle, so TIMEOUT strobe cycles elapse.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IFETCH  = 3'd1,
    DACCESS = 3'd2,
    IRESP   = 3'd3,
    DRESP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-3:0]   word_q, word_d;       // latched word address
  logic [DATA_W-1:0]   wdata_q, wdata_d;     // latched store data
  logic                write_q, write_d;     // latched access is a store
  logic [CNT_W-1:0]    cnt_q, cnt_d;         // watchdog
  logic [DATA_W-1:0]   imemload_q, imemload_d;
  logic [DATA_W-1:0]   dmemload_q, dmemload_d;
  logic                err_q, err_d;

  // Byte-offset bits of the request addresses are irrelevant: the RAM is
  // word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

  logic watchdog_fire;
  assign watchdog_fire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef DP_MEM_ILAST_BUF_EN
  logic                ibuf_valid_q, ibuf_valid_d;
  logic [ADDR_W-3:0]   ibuf_word_q, ibuf_word_d;
  logic [DATA_W-1:0]   ibuf_data_q, ibuf_data_d;
  logic                ibuf_match;
  assign ibuf_match = ibuf_valid_q && (ibuf_word_q == imemaddr[ADDR_W-1:2]);
`endif

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    err_d      = err_q;
`ifdef DP_MEM_ILAST_BUF_EN
    ibuf_valid_d = ibuf_valid_q;
    ibuf_word_d  = ibuf_word_q;
    ibuf_data_d  = ibuf_data_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dmemREN || dmemWEN) begin
          state_d = DACCESS;
          word_d  = dmemaddr[ADDR_W-1:2];
          wdata_d = dmemstore;
          write_d = dmemWEN;
          // Ambiguous request: executed as a store but flagged.
          if (dmemREN && dmemWEN) begin
            err_d = 1'b1;
          end
`ifdef DP_MEM_ILAST_BUF_EN
          // Drop a buffered instruction that this store is about to overwrite.
          if (dmemWEN && ibuf_valid_q && (ibuf_word_q == dmemaddr[ADDR_W-1:2])) begin
            ibuf_valid_d = 1'b0;
          end
`endif
        end else if (imemREN && !halt) begin
          word_d  = imemaddr[ADDR_W-1:2];
          write_d = 1'b0;
`ifdef DP_MEM_ILAST_BUF_EN
          if (ibuf_match) begin
            state_d    = IRESP;
            imemload_d = ibuf_data_q;
          end else begin
            state_d = IFETCH;
          end
`else
          state_d = IFETCH;
`endif
        end
      end

      IFETCH: begin
        if (ramready) begin
          state_d    = IRESP;
          imemload_d = ramload;
`ifdef DP_MEM_ILAST_BUF_EN
          ibuf_valid_d = 1'b1;
          ibuf_word_d  = word_q;
          ibuf_data_d  = ramload;
`endif
        end else if (watchdog_fire) begin
          state_d    = IRESP;
          imemload_d = '0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DACCESS: begin
        if (ramready) begin
          state_d = DRESP;
          if (!write_q) begin
            dmemload_d = ramload;
          end
        end else if (watchdog_fire) begin
          state_d    = DRESP;
          dmemload_d = '0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IRESP, DRESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      word_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      imemload_q <= '0;
      dmemload_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
      err_q      <= err_d;
    end
  end

`ifdef DP_MEM_ILAST_BUF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ibuf_valid_q <= 1'b0;
      ibuf_word_q  <= '0;
      ibuf_data_q  <= '0;
    end else begin
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_word_q  <= ibuf_word_d;
      ibuf_data_q  <= ibuf_data_d;
    end
  end
`endif

  // Strobes and hits are decoded from the registered state, so they change
  // only on clock edges and are low in IDLE and the response states.
  assign ramREN   = (state_q == IFETCH) || ((state_q == DACCESS) && !write_q);
  assign ramWEN   = (state_q == DACCESS) && write_q;
  assign ramaddr  = {word_q, 2'b00};
  assign ramstore = wdata_q;
  assign ihit     = (state_q == IRESP);
  assign dhit     = (state_q == DRESP);
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign mem_err  = err_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
module tb_dp_mem_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 6;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          halt;
  logic          imemREN;
  logic [AW-1:0] imemaddr;
  logic          ihit;
  logic [DW-1:0] imemload;
  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          dhit;
  logic [DW-1:0] dmemload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ramready;
  logic          mem_err;

  dp_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // ---------------- RAM model: ready after ready_delay wait cycles ----------
  logic [DW-1:0] init_mem [128];
  logic [DW-1:0] ram_mem  [128];
  logic          ram_init;
  int            strobe_cnt;
  int            ready_delay;

  assign ramready = (ramREN || ramWEN) && (strobe_cnt == ready_delay);
  assign ramload  = ram_mem[ramaddr[8:2]];

  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= init_mem[i];
    end else if (ramWEN && ramready) begin
      ram_mem[ramaddr[8:2]] <= ramstore;
    end
    if (!nRST || !(ramREN || ramWEN)) strobe_cnt <= 0;
    else strobe_cnt <= strobe_cnt + 1;
  end

  // ---------------- reference model state -----------------------------------
  logic [DW-1:0] model_mem [128];
  bit            model_err;
  bit            bvalid;
  logic [6:0]    bword;
  logic [DW-1:0] bdata;
  logic [DW-1:0] last_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One transaction: optional fetch, optional data access, optional halt.
  // Called and returning #1 after a rising edge.
  task automatic access(input bit do_i, input bit do_r, input bit do_w, input bit hlt,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input int dly);
    bit dat   = do_r || do_w;
    bit st    = do_w;
    bit i_exp = do_i && !hlt;
    bit tmo;
    bit done  = 0;
    int d_lat = 0, d_str = 0, i_lat = 0, i_str = 0, i_hit_cyc = 0;
    int ren_exp = 0, wen_exp = 0;
    int dh_cnt = 0, ih_cnt = 0, both_cnt = 0, ren_n = 0, wen_n = 0, addr_bad = 0;
    int last_cyc = 0;
    logic [31:0] exp_d = '0, exp_i = '0;

    // Expected behaviour, derived from the access rules.
    if (dat) begin
      tmo   = (dly >= TO);
      d_lat = tmo ? TO + 1 : dly + 2;
      d_str = tmo ? TO : dly + 1;
      if (!st) exp_d = tmo ? 32'h0 : model_mem[da[8:2]];
      else if (!tmo) model_mem[da[8:2]] = wd;
      if (st && bvalid && bword == da[8:2]) bvalid = 0;
      if ((do_r && do_w) || tmo) model_err = 1;
      if (st) wen_exp += d_str; else ren_exp += d_str;
    end
    if (i_exp) begin
      if (bvalid && bword == ia[8:2]) begin
        i_lat = 1;
        exp_i = bdata;
      end else begin
        tmo   = (dly >= TO);
        i_lat = tmo ? TO + 1 : dly + 2;
        i_str = tmo ? TO : dly + 1;
        exp_i = tmo ? 32'h0 : model_mem[ia[8:2]];
`ifdef DP_MEM_ILAST_BUF_EN
        if (!tmo) begin
          bvalid = 1;
          bword  = ia[8:2];
          bdata  = exp_i;
        end
`endif
        ren_exp += i_str;
      end
      // A fetch waiting behind a data access is sampled two cycles after dhit.
      i_hit_cyc = (dat ? d_lat + 1 : 0) + i_lat;
    end

    halt = hlt; imemREN = do_i; imemaddr = ia;
    dmemREN = do_r; dmemWEN = do_w; dmemaddr = da; dmemstore = wd;
    ready_delay = dly;

    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(posedge CLK); #1;
      if (ramWEN) begin
        wen_n++;
        if (ramaddr != {da[31:2], 2'b00} || ramstore != wd) addr_bad++;
      end
      if (ramREN) begin
        ren_n++;
        if (dat && !st && dh_cnt == 0) begin
          if (ramaddr != {da[31:2], 2'b00}) addr_bad++;
        end else if (ramaddr != {ia[31:2], 2'b00}) addr_bad++;
      end
      if (ihit && dhit) both_cnt++;
      if (dhit) begin
        dh_cnt++;
        if (dh_cnt == 1) begin
          check("dhit_latency", cyc, d_lat);
          if (!st) check("dmemload", dmemload, exp_d);
        end
        dmemREN = 0; dmemWEN = 0;
      end
      if (ihit) begin
        ih_cnt++;
        if (ih_cnt == 1 && i_exp) begin
          check("ihit_latency", cyc, i_hit_cyc);
          check("imemload", imemload, exp_i);
        end
        if (!hlt) imemREN = 0;
      end
      if (!done && (dh_cnt > 0 || !dat) && (ih_cnt > 0 || !i_exp)) begin
        done = 1;
        last_cyc = cyc;
      end
      if (done && cyc >= last_cyc + 4) break;
    end

    if (!done) check("hit_wait_expired", 1, 0);
    check("dhit_count", dh_cnt, dat);
    check("ihit_count", ih_cnt, i_exp);
    check("hits_together", both_cnt, 0);
    check("ramREN_cycles", ren_n, ren_exp);
    check("ramWEN_cycles", wen_n, wen_exp);
    check("ram_addr_data", addr_bad, 0);
    check("mem_err", mem_err, model_err);
    if (i_exp) last_i = exp_i;
    else if (dat) check("imemload_hold", imemload, last_i);
    $display("txn i=%0b r=%0b w=%0b halt=%0b ia=%h da=%h wd=%h dly=%0d dhit@%0d ihit@%0d err=%0b",
             do_i, do_r, do_w, hlt, ia, da, wd, dly, d_lat, i_hit_cyc, mem_err);
    imemREN = 0; halt = 0; dmemREN = 0; dmemWEN = 0;
  endtask

  task automatic apply_reset();
    nRST = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_strobes", {ihit, dhit, ramREN, ramWEN, mem_err}, 5'b0);
    check("reset_imemload", imemload, 0);
    check("reset_dmemload", dmemload, 0);
    check("reset_ramaddr", ramaddr, 0);
    check("reset_ramstore", ramstore, 0);
    nRST = 1;
    model_err = 0;
    bvalid = 0;
    last_i = '0;
  endtask

  initial begin
    int kind, dly;
    logic [31:0] ia, da, wd;
    halt = 0; imemREN = 0; imemaddr = '0;
    dmemREN = 0; dmemWEN = 0; dmemaddr = '0; dmemstore = '0;
    ready_delay = 0;
    bword = '0; bdata = '0;
    for (int i = 0; i < 128; i++) begin
      init_mem[i]  = $urandom;
    end
    init_mem[0] = 32'h0050_0093;
    for (int i = 0; i < 128; i++) model_mem[i] = init_mem[i];
    ram_init = 1;
    apply_reset();
    ram_init = 0;

    // Directed cases
    access(1, 0, 0, 0, 32'h0,   32'h0,   32'h0,         0);  // first fetch
    access(1, 1, 0, 0, 32'h4,   32'h100, 32'h0,         1);  // data wins
    access(0, 0, 1, 0, 32'h0,   32'h103, 32'hDEADBEEF,  3);  // delayed store
    access(0, 1, 0, 0, 32'h0,   32'h100, 32'h0,         0);  // read back
    access(1, 1, 0, 1, 32'h10,  32'h20,  32'h0,         1);  // halted fetch
    access(1, 0, 0, 0, 32'h8,   32'h0,   32'h0,         0);  // fetch 0x8
    access(1, 0, 0, 0, 32'h8,   32'h0,   32'h0,         0);  // again
    access(0, 0, 1, 0, 32'h0,   32'h8,   32'h1234_5678, 0);  // store 0x8
    access(1, 0, 0, 0, 32'h8,   32'h0,   32'h0,         0);  // fetch 0x8
    access(0, 1, 0, 0, 32'h0,   32'h40,  32'h0,         20); // timeout

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      ia = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      da = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      wd = $urandom;
      dly = ($urandom_range(0, 4) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
      case (kind)
        0, 1: access(1, 0, 0, 0, ia, da, wd, dly);
        2:    access(0, 1, 0, 0, ia, da, wd, dly);
        3:    access(0, 0, 1, 0, ia, da, wd, dly);
        4:    access(1, 1, 0, 0, ia, da, wd, dly);
        5:    access(1, 0, 1, 0, ia, da, wd, dly);
        6:    access(1, $urandom_range(0, 1) == 1, 0, 1, ia, da, wd, dly);
        default: access(0, 1, 1, 0, ia, da, wd, dly);
      endcase
    end

    // Sticky error clears only on reset
    apply_reset();
    check("err_after_reset", mem_err, 0);
    access(0, 1, 0, 0, 32'h0, 32'h100, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
- Memory-side responder for the datapath/cache request interface. It receives the datapath's instruction-fetch and data load/store requests and returns instruction/data words with one-cycle hit pulses (ihit/dhit).
- It serializes the two request streams onto a single-port RAM with a ready handshake. Data requests have priority over instruction fetches.
- It sits between the datapath and the RAM model or arbiter, standing in for the cache level.

Parameters:
- ADDR_W, 32: address width of datapath and RAM addresses.
- DATA_W, 32: word width.
- TIMEOUT, 255: max cycles to wait for ramready per access; 0 disables the watchdog.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- halt  in  1  datapath halted; no new instruction fetches accepted
- imemREN  in  1  instruction fetch request
- imemaddr  in  ADDR_W  fetch address
- ihit  out  1  one-cycle pulse: imemload valid
- imemload  out  DATA_W  fetched instruction
- dmemREN  in  1  data load request
- dmemWEN  in  1  data store request
- dmemaddr  in  ADDR_W  data address
- dmemstore  in  DATA_W  store data
- dhit  out  1  one-cycle pulse: load data valid or store complete
- dmemload  out  DATA_W  loaded data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM word address, bits [1:0] forced to 0
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramready  in  1  RAM access complete this cycle
- mem_err  out  1  sticky error flag

Behaviour:
- Interface: one clock, CLK; reset nRST is synchronous and active-low.
- Reset (nRST=0 at a CLK edge): state IDLE; ihit, dhit, ramREN, ramWEN, mem_err = 0; imemload, dmemload, ramaddr, ramstore = 0; watchdog counter = 0.
- States: IDLE, IFETCH, DACCESS, IRESP, DRESP.
- IDLE transitions:
  - dmemREN or dmemWEN -> DACCESS. Latch address, store data and rw (write if dmemWEN).
  - Otherwise, imemREN and !halt -> IFETCH. Latch address.
  - Otherwise stay in IDLE.
  - Data wins when both streams request in the same cycle.
- IFETCH / DACCESS:
  - Drive ramaddr and ramstore from the latched values; assert ramREN (or ramWEN for a store) every cycle in the state.
  - On ramready=1, capture ramload (reads only) and move to IRESP or DRESP.
  - The watchdog counts cycles in the state. When it reaches TIMEOUT, set mem_err, load 0 as data, and move to the response state.
- IRESP / DRESP: registered ihit or dhit = 1 for exactly this cycle; imemload or dmemload holds the captured word; next state is IDLE.
- Latency: request sampled in IDLE at edge N. Strobes are high during cycle N+1. If ramready=1 in cycle N+1, the hit is high in cycle N+2. Minimum is 2 cycles; each ramready wait cycle adds one.
- The requester holds its request until the hit. Request addresses are latched, so changes mid-access are ignored. A request dropped mid-access still completes and still pulses its hit; abort is not supported.
- In IDLE the cycle after a hit, a still-asserted request starts a new access. The datapath clears or advances its request on the hit edge.
- dmemREN and dmemWEN both high: treated as a store and mem_err is set.
- imemload and dmemload hold their last value between hits. ihit and dhit are never high in the same cycle.
- halt blocks only new fetches. An in-flight fetch completes; data requests are still served.
- Strobes deassert in response states and in IDLE.
- mem_err clears only on reset.

Optional Feature:
- Macro: DP_MEM_ILAST_BUF_EN
- Defined: a one-entry buffer holds the last fetched address and instruction, with a valid bit.
  - Lookup: in IDLE, a fetch (with no data request pending) whose address matches a valid entry goes directly to IRESP without a RAM access (hit at N+1).
  - Invalidation: any store to a matching address clears valid; reset also clears valid.
  - Fill: a completed RAM fetch sets the entry. A timed-out fetch does not fill the entry.
- Not defined: every fetch accesses RAM.

Test Plan:
- Reset, then fetch at 0x0 with RAM returning 0x00500093 and ramready on its first strobe cycle -> ramREN/ramaddr=0x0 in cycle 1, ihit=1 and imemload=0x00500093 in cycle 2, ihit=0 in cycle 3.
- dmemREN and imemREN raised together, addr 0x100/0x4 -> data access first, dhit; then fetch, ihit; never simultaneous.
- Store 0xDEADBEEF at 0x103, ramready delayed 3 cycles -> ramWEN held 4 cycles, ramaddr=0x100, ramstore=0xDEADBEEF, dhit exactly once.
- TIMEOUT=4, ramready tied 0 -> after 4 strobe cycles, dhit with dmemload=0 and mem_err=1, sticky until nRST=0.
- halt=1 with imemREN high in IDLE -> no ramREN, no ihit; a dmemREN still completes.
- DP_MEM_ILAST_BUF_EN: fetch 0x8 twice -> second ihit one cycle after request, no RAM strobe; store to 0x8, then fetch -> RAM access again.
